ycbcr2rgb: RTL and testbench

AXI-Stream video converter from BT.709 limited-range YCbCr 4:4:4 back to RGB 4:4:4. It is the inverse of the capture-path RGB-to-YCbCr stage and sits on the display/readback path, before HDMI output.
- Fixed-point Q8 datapath with a 4-stage pipeline, per-pixel saturation and full ready/valid backpressure.
- Carries N pixels per beat.

---
 rtl/ycbcr_pkg.sv | 54 +++++
 rtl/ycbcr2rgb_pix.sv | 74 +++++++
 rtl/ycbcr2rgb.sv | 70 +++++++
 tb/tb_ycbcr2rgb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ycbcr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ycbcr_pkg
// Brief   : Shared constants for the BT.709 limited-range YCbCr -> RGB path.
// Revision: 1.0  initial release
// ============================================================================
package ycbcr_pkg;

    // Q8 BT.709 inverse-matrix coefficients
    localparam int c_coef_y  = 298;
    localparam int c_coef_rv = 459;
    localparam int c_coef_gu = 55;
    localparam int c_coef_gv = 136;
    localparam int c_coef_bu = 541;

    // Offsets at 8-bit scale; multiplied by 2^(w-8) for wider components
    localparam int c_off_y   = 16;
    localparam int c_off_c   = 128;
    localparam int c_shift   = 8;

    localparam int c_num_comp = 3;
    localparam int c_comp_y   = 0;
    localparam int c_comp_cb  = 1;
    localparam int c_comp_cr  = 2;
    localparam int c_ch_b     = 0;
    localparam int c_ch_g     = 1;
    localparam int c_ch_r     = 2;

    // Matrix entry for output channel ch (B/G/R) and input component comp (Y/Cb/Cr)
    function automatic int coef(input int ch, input int comp);
        int v;
        v = 0;
        if (comp == c_comp_y)                          v = c_coef_y;
        else if (ch == c_ch_r && comp == c_comp_cr)    v = c_coef_rv;
        else if (ch == c_ch_g && comp == c_comp_cb)    v = -c_coef_gu;
        else if (ch == c_ch_g && comp == c_comp_cr)    v = -c_coef_gv;
        else if (ch == c_ch_b && comp == c_comp_cb)    v = c_coef_bu;
        return v;
    endfunction

    function automatic int comp_bias(input int comp, input int w);
        return ((comp == c_comp_y) ? c_off_y : c_off_c) << (w - 8);
    endfunction

    function automatic int pix_lsb(input int p, input int w);
        return c_num_comp * w * p;
    endfunction

    function automatic int comp_lsb(input int comp, input int w);
        return comp * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ycbcr2rgb_pix.sv
`default_nettype none
// ============================================================================
// Module  : ycbcr2rgb_pix
// Brief   : One pixel's 4-stage YCbCr->RGB datapath (offset, multiply, sum,
//           shift+clamp). YCBCR2RGB_ROUND_EN selects round-half-up in S4.
// Revision: 1.0  initial release
// ============================================================================
module ycbcr2rgb_pix
    import ycbcr_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic [3*DATA_WIDTH-1:0] i_ycbcr,
    output logic [3*DATA_WIDTH-1:0] o_rgb
);

    localparam int c_aw = DATA_WIDTH + 12;

`ifdef YCBCR2RGB_ROUND_EN
    localparam logic signed [c_aw-1:0] c_rnd = c_aw'(1 << (c_shift - 1));
`else
    localparam logic signed [c_aw-1:0] c_rnd = '0;
`endif
    localparam logic signed [c_aw-1:0] c_max = c_aw'((1 << DATA_WIDTH) - 1);

    logic signed [DATA_WIDTH:0] r_comp [c_num_comp];
    logic signed [c_aw-1:0]     r_prod [c_num_comp][c_num_comp];
    logic signed [c_aw-1:0]     r_sum  [c_num_comp];
    logic signed [c_aw-1:0]     w_shr  [c_num_comp];
    logic [DATA_WIDTH-1:0]      w_clamp[c_num_comp];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < c_num_comp; c++) begin
                r_comp[c] <= '0;
                r_sum[c]  <= '0;
                for (int k = 0; k < c_num_comp; k++) begin
                    r_prod[c][k] <= '0;
                end
            end
            o_rgb <= '0;
        end else if (i_en) begin
            for (int c = 0; c < c_num_comp; c++) begin
                r_comp[c] <= $signed({1'b0, i_ycbcr[comp_lsb(c, DATA_WIDTH) +: DATA_WIDTH]})
                           - $signed((DATA_WIDTH + 1)'(comp_bias(c, DATA_WIDTH)));
            end
            // Zero-coefficient products reduce to constants in synthesis
            for (int ch = 0; ch < c_num_comp; ch++) begin
                for (int c = 0; c < c_num_comp; c++) begin
                    r_prod[ch][c] <= c_aw'(r_comp[c]) * c_aw'(coef(ch, c));
                end
                r_sum[ch] <= r_prod[ch][0] + r_prod[ch][1] + r_prod[ch][2];
                o_rgb[comp_lsb(ch, DATA_WIDTH) +: DATA_WIDTH] <= w_clamp[ch];
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < c_num_comp; ch++) begin
            w_shr[ch]   = (r_sum[ch] + c_rnd) >>> c_shift;
            w_clamp[ch] = w_shr[ch][DATA_WIDTH-1:0];
            if (w_shr[ch][c_aw-1]) begin
                w_clamp[ch] = '0;
            end else if (w_shr[ch] > c_max) begin
                w_clamp[ch] = '1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ycbcr2rgb.sv
`default_nettype none
// ============================================================================
// Module  : ycbcr2rgb
// Brief   : AXI-Stream BT.709 limited-range YCbCr 4:4:4 to RGB converter,
//           N pixels per beat, 4-cycle latency. Build option: YCBCR2RGB_ROUND_EN.
// Revision: 1.0  initial release
// ============================================================================
module ycbcr2rgb
    import ycbcr_pkg::*;
#(
    parameter int PIX_PER_CLOCK = 1,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                                  clk_in,
    input  logic                                  reset,
    input  logic [3*DATA_WIDTH*PIX_PER_CLOCK-1:0] rdata,
    input  logic                                  rlast,
    input  logic                                  ruser,
    input  logic                                  rvalid,
    output logic                                  rready,
    output logic [3*DATA_WIDTH*PIX_PER_CLOCK-1:0] tdata,
    output logic                                  tlast,
    output logic                                  tuser,
    output logic                                  tvalid,
    input  logic                                  tready
);

    localparam int c_pix_w = c_num_comp * DATA_WIDTH;
    localparam int c_depth = 4;

    logic               w_en;
    logic [c_depth-1:0] r_vld;
    logic [c_depth-1:0] r_last;
    logic [c_depth-1:0] r_user;

    // Whole pipeline moves as one: it may advance whenever the output slot frees
    assign w_en   = ~r_vld[c_depth-1] | tready;
    assign rready = w_en;
    assign tvalid = r_vld[c_depth-1];
    assign tlast  = r_last[c_depth-1];
    assign tuser  = r_user[c_depth-1];

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_vld  <= '0;
            r_last <= '0;
            r_user <= '0;
        end else if (w_en) begin
            r_vld  <= {r_vld[c_depth-2:0],  rvalid};
            r_last <= {r_last[c_depth-2:0], rvalid & rlast};
            r_user <= {r_user[c_depth-2:0], rvalid & ruser};
        end
    end

    generate
        for (genvar p = 0; p < PIX_PER_CLOCK; p++) begin : g_pix
            ycbcr2rgb_pix #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_pix (
                .clk     (clk_in),
                .rst     (reset),
                .i_en    (w_en),
                .i_ycbcr (rdata[pix_lsb(p, DATA_WIDTH) +: c_pix_w]),
                .o_rgb   (tdata[pix_lsb(p, DATA_WIDTH) +: c_pix_w])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ycbcr2rgb.sv
`default_nettype none
// ============================================================================
// Module  : tb_ycbcr2rgb
// Brief   : Scoreboard bench for ycbcr2rgb (8-bit x1 and 10-bit x2 instances).
// Revision: 1.0  initial release
// ============================================================================
module tb_ycbcr2rgb;

    typedef struct {
        logic [59:0] d;
        logic        l;
        logic        u;
        int          cyc;
        bit          lat;
    } exp_t;

`ifdef YCBCR2RGB_ROUND_EN
    localparam logic [23:0] c_white = 24'hFFFFFF;
    localparam logic [23:0] c_red   = 24'hFF0100;
    localparam logic [23:0] c_zero  = 24'h004D00;
`else
    localparam logic [23:0] c_white = 24'hFEFEFE;
    localparam logic [23:0] c_red   = 24'hFF0000;
    localparam logic [23:0] c_zero  = 24'h004C00;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, d_rlast, d_ruser, d_rvalid, d_rready, d_tlast, d_tuser, d_tvalid, d_tready;
    logic [23:0] d_rdata, d_tdata;
    logic        rst2, e_rlast, e_ruser, e_rvalid, e_rready, e_tlast, e_tuser, e_tvalid, e_tready;
    logic [59:0] e_rdata, e_tdata;

    ycbcr2rgb #(.PIX_PER_CLOCK(1), .DATA_WIDTH(8)) u_dut1 (
        .clk_in(clk), .reset(rst1), .rdata(d_rdata), .rlast(d_rlast), .ruser(d_ruser),
        .rvalid(d_rvalid), .rready(d_rready), .tdata(d_tdata), .tlast(d_tlast),
        .tuser(d_tuser), .tvalid(d_tvalid), .tready(d_tready));

    ycbcr2rgb #(.PIX_PER_CLOCK(2), .DATA_WIDTH(10)) u_dut2 (
        .clk_in(clk), .reset(rst2), .rdata(e_rdata), .rlast(e_rlast), .ruser(e_ruser),
        .rvalid(e_rvalid), .rready(e_rready), .tdata(e_tdata), .tlast(e_tlast),
        .tuser(e_tuser), .tvalid(e_tvalid), .tready(e_tready));

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   out1 = 0;
    int   out2 = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t m1, m2;
    logic [23:0] held1;
    bit   stall1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference conversion computed with plain integer arithmetic
    function automatic logic [59:0] model(input logic [59:0] d, input int w, input int ppc);
        logic [59:0] res;
        int k, mx, base, yy, cb, cr, rr, gg, bb;
        res = '0;
        k   = 1 << (w - 8);
        mx  = (1 << w) - 1;
        for (int p = 0; p < ppc; p++) begin
            base = 3 * w * p;
            yy = int'((d >> base) & 60'(mx)) - 16 * k;
            cb = int'((d >> (base + w)) & 60'(mx)) - 128 * k;
            cr = int'((d >> (base + 2 * w)) & 60'(mx)) - 128 * k;
            rr = 298 * yy + 459 * cr;
            gg = 298 * yy - 55 * cb - 136 * cr;
            bb = 298 * yy + 541 * cb;
`ifdef YCBCR2RGB_ROUND_EN
            rr += 128; gg += 128; bb += 128;
`endif
            rr = rr >>> 8; gg = gg >>> 8; bb = bb >>> 8;
            rr = (rr < 0) ? 0 : (rr > mx) ? mx : rr;
            gg = (gg < 0) ? 0 : (gg > mx) ? mx : gg;
            bb = (bb < 0) ? 0 : (bb > mx) ? mx : bb;
            res |= (60'(bb) << base) | (60'(gg) << (base + w)) | (60'(rr) << (base + 2 * w));
        end
        return res;
    endfunction

    function automatic logic [23:0] m8(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        logic [59:0] t;
        t = model({36'd0, cr, cb, y}, 8, 1);
        return t[23:0];
    endfunction

    always @(negedge clk) begin
        if (!rst1 && d_tvalid && d_tready) begin
            out1++;
            chk("dut1_expected_beat", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                m1 = q1.pop_front();
                chk("dut1_tdata", 64'(d_tdata), 64'(m1.d[23:0]));
                chk("dut1_tlast", 64'(d_tlast), 64'(m1.l));
                chk("dut1_tuser", 64'(d_tuser), 64'(m1.u));
                if (m1.lat) chk("dut1_latency", 64'(cyc - m1.cyc), 64'd4);
            end
        end
        if (!rst1 && d_tvalid && !d_tready) begin
            chk("dut1_rready_stall", 64'(d_rready), 64'd0);
            if (stall1) chk("dut1_tdata_stable", 64'(d_tdata), 64'(held1));
            held1  = d_tdata;
            stall1 = 1;
        end else begin
            stall1 = 0;
        end
        if (!rst2 && e_tvalid && e_tready) begin
            out2++;
            chk("dut2_expected_beat", 64'(q2.size() != 0), 64'd1);
            if (q2.size() != 0) begin
                m2 = q2.pop_front();
                chk("dut2_tdata", 64'(e_tdata), 64'(m2.d));
                if (m2.lat) chk("dut2_latency", 64'(cyc - m2.cyc), 64'd4);
            end
        end
    end

    task automatic send1(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                         input logic l, input logic u, input logic [23:0] exp, input bit lat);
        int n;
        d_rdata = {cr, cb, y}; d_rlast = l; d_ruser = u; d_rvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!d_rready && n < 50);
        chk("dut1_accept", 64'(d_rready), 64'd1);
        q1.push_back('{d: 60'(exp), l: l, u: u, cyc: cyc, lat: lat});
        @(posedge clk); #1;
        d_rvalid = 1'b0; d_rlast = 1'b0; d_ruser = 1'b0;
    endtask

    task automatic send2(input logic [59:0] data, input logic [59:0] exp, input bit lat);
        int n;
        e_rdata = data; e_rvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!e_rready && n < 50);
        chk("dut2_accept", 64'(e_rready), 64'd1);
        q2.push_back('{d: exp, l: 1'b0, u: 1'b0, cyc: cyc, lat: lat});
        @(posedge clk); #1;
        e_rvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 200) begin @(posedge clk); n++; end
        chk("drain_q1", 64'(q1.size()), 64'd0);
        chk("drain_q2", 64'(q2.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0;
        logic [7:0] y, cb, cr;
        logic [59:0] d2;
        rst1 = 1; rst2 = 1;
        d_rdata = '0; d_rlast = 0; d_ruser = 0; d_rvalid = 0; d_tready = 1;
        e_rdata = '0; e_rlast = 0; e_ruser = 0; e_rvalid = 0; e_tready = 1;
        repeat (3) @(posedge clk);
        #1 rst1 = 0; rst2 = 0;
        @(negedge clk);
        chk("rst_tvalid", 64'(d_tvalid), 64'd0);
        chk("rst_tdata", 64'(d_tdata), 64'd0);
        chk("rst_tlast", 64'(d_tlast), 64'd0);
        chk("rst_tuser", 64'(d_tuser), 64'd0);
        chk("rst_rready", 64'(d_rready), 64'd1);
        chk("rst2_tvalid", 64'(e_tvalid), 64'd0);
        chk("rst2_tdata", 64'(e_tdata), 64'd0);
        @(posedge clk); #1;

        // Black: a single output pulse after 4 cycles
        n0 = out1;
        send1(8'd16, 8'd128, 8'd128, 0, 0, 24'h000000, 1);
        drain();
        chk("black_pulses", 64'(out1 - n0), 64'd1);

        // White, red clamp and all-zero, back to back
        send1(8'd235, 8'd128, 8'd128, 0, 0, c_white, 1);
        send1(8'd63,  8'd102, 8'd240, 0, 0, c_red,   1);
        send1(8'd0,   8'd0,   8'd0,   0, 0, c_zero,  1);
        drain();

        // Ramp with a 5-cycle tready drop mid-stream
        n0 = out1;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    y = 8'(16 + i * 13); cb = 8'(i * 16); cr = 8'(255 - i * 15);
                    send1(y, cb, cr, 0, 0, m8(y, cb, cr), 0);
                end
            end
            begin
                repeat (8) @(posedge clk);
                #1 d_tready = 0;
                @(negedge clk);
                chk("bp_rready_drop", 64'(d_rready), 64'd0);
                chk("bp_tvalid_held", 64'(d_tvalid), 64'd1);
                repeat (5) @(posedge clk);
                #1 d_tready = 1;
            end
        join
        drain();
        chk("bp_beat_count", 64'(out1 - n0), 64'd16);

        // One line: tuser on beat 0, tlast on beat 7, random input gaps
        n0 = out1;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            y = 8'(i * 30); cb = 8'(255 - i * 20); cr = 8'(i * 31);
            send1(y, cb, cr, i == 7, i == 0, m8(y, cb, cr), 0);
        end
        drain();
        chk("line_beat_count", 64'(out1 - n0), 64'd8);

        // Reset with 3 beats in flight
        n0 = out1;
        for (int i = 0; i < 3; i++) begin
            y = 8'(100 + i); send1(y, 8'd90, 8'd170, 0, 0, m8(y, 8'd90, 8'd170), 0);
        end
        rst1 = 1;
        q1.delete();
        @(posedge clk); #1 rst1 = 0;
        @(negedge clk);
        chk("mid_rst_tvalid", 64'(d_tvalid), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("mid_rst_no_output", 64'(out1 - n0), 64'd0);
        send1(8'd16, 8'd128, 8'd128, 0, 0, 24'h000000, 1);
        drain();
        chk("mid_rst_recover", 64'(out1 - n0), 64'd1);

        // 10-bit, 2 pixels per beat: black, ramp, mid-stream reset, black
        n0 = out2;
        send2({2{10'd512, 10'd512, 10'd64}}, 60'd0, 1);
        for (int i = 0; i < 4; i++) begin
            d2 = {10'(1023 - i * 80), 10'(i * 90 + 7), 10'(200 + i * 100),
                  10'(i * 250), 10'(1023 - i * 70), 10'(64 + i * 120)};
            send2(d2, model(d2, 10, 2), 0);
        end
        drain();
        chk("dut2_beat_count", 64'(out2 - n0), 64'd5);
        n0 = out2;
        for (int i = 0; i < 3; i++) begin
            d2 = {10'(900 - i), 10'd300, 10'd700, 10'd100, 10'(800 + i), 10'd500};
            send2(d2, model(d2, 10, 2), 0);
        end
        rst2 = 1;
        q2.delete();
        @(posedge clk); #1 rst2 = 0;
        @(negedge clk);
        chk("dut2_mid_rst_tvalid", 64'(e_tvalid), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("dut2_mid_rst_no_output", 64'(out2 - n0), 64'd0);
        send2({2{10'd512, 10'd512, 10'd64}}, 60'd0, 1);
        drain();
        chk("dut2_mid_rst_recover", 64'(out2 - n0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
